// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM states, default bit period and id-width helper for the UART blocks
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_DRAIN     = 2'd3
  } arb_state_e;

  localparam int CLKS_PER_BIT = 543;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// rtl/uart_rr_picker.sv - combinational rotate-priority picker, first set bit after last
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic               any,
  output logic [IDW-1:0]     win_id
);

  always_comb begin
    any    = |req;
    win_id = last;
    // Scan farthest-first so the candidate nearest to last+1 is the one left standing.
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[(int'(last) + i) % NUM_REQ]) begin
        win_id = IDW'((int'(last) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_txx among NUM_REQ byte requesters
// Optional grant-to-done watchdog enabled by `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int clks_per_bit   = CLKS_PER_BIT,
  parameter int TIMEOUT_CYCLES = clks_per_bit * 12,
  parameter int IDW            = id_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_data,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic [NUM_REQ-1:0]   o_sent,
  output logic                 o_busy,
  output logic [IDW-1:0]       o_grant_id,
  output logic                 o_tx_data_avail,
  output logic [7:0]           o_tx_databyte,
  input  logic                 i_tx_active,
  input  logic                 i_tx_done,
  output logic                 o_timeout
);

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] sent_q, sent_d;
  logic               busy_q, busy_d;
  logic               avail_q, avail_d;
  logic [7:0]         byte_q, byte_d;
  logic               timeout_q, timeout_d;

  logic               pick_any;
  logic [IDW-1:0]     pick_id;
  logic               tmo_hit;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .req    (i_req),
    .last   (last_q),
    .any    (pick_any),
    .win_id (pick_id)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tmo_hit = (state_q == ST_START || state_q == ST_WAIT_DONE) &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && pick_any) begin
      cnt_d = '0;
    end else if (state_q == ST_START || state_q == ST_WAIT_DONE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign tmo_hit            = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    ack_d     = '0;
    sent_d    = '0;
    avail_d   = avail_q;
    byte_d    = byte_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          ack_d[pick_id] = 1'b1;
          byte_d         = i_data[{pick_id, 3'b000} +: 8];
          grant_d        = pick_id;
          avail_d        = 1'b1;
          state_d        = ST_START;
        end
      end
      ST_START: begin
        if (tmo_hit) begin
          avail_d   = 1'b0;
          timeout_d = 1'b1;
          last_d    = grant_q;
          state_d   = ST_DRAIN;
        end else if (i_tx_active) begin
          avail_d = 1'b0;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // A real completion wins over a watchdog expiry in the same cycle.
        if (i_tx_done) begin
          sent_d[grant_q] = 1'b1;
          last_d          = grant_q;
          state_d         = ST_DRAIN;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          last_d    = grant_q;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!i_tx_active) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= IDW'(NUM_REQ - 1);
      grant_q   <= '0;
      ack_q     <= '0;
      sent_q    <= '0;
      busy_q    <= 1'b0;
      avail_q   <= 1'b0;
      byte_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      sent_q    <= sent_d;
      busy_q    <= busy_d;
      avail_q   <= avail_d;
      byte_q    <= byte_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_ack           = ack_q;
  assign o_sent          = sent_q;
  assign o_busy          = busy_q;
  assign o_grant_id      = grant_q;
  assign o_tx_data_avail = avail_q;
  assign o_tx_databyte   = byte_q;
  assign o_timeout       = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a behavioural uart_txx model
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int CPB   = 16;
  localparam int FRAME = CPB * 10;
  localparam int TMO   = 50;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     i_req = '0;
  logic [8*NREQ-1:0]   i_data = '0;
  logic [NREQ-1:0]     o_ack;
  logic [NREQ-1:0]     o_sent;
  logic                o_busy;
  logic [IDW-1:0]      o_grant_id;
  logic                o_tx_data_avail;
  logic [7:0]          o_tx_databyte;
  logic                tx_active = 1'b0;
  logic                tx_done = 1'b0;
  logic                o_timeout;

  always #2 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ        (NREQ),
    .clks_per_bit   (CPB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req           (i_req),
    .i_data          (i_data),
    .o_ack           (o_ack),
    .o_sent          (o_sent),
    .o_busy          (o_busy),
    .o_grant_id      (o_grant_id),
    .o_tx_data_avail (o_tx_data_avail),
    .o_tx_databyte   (o_tx_databyte),
    .i_tx_active     (tx_active),
    .i_tx_done       (tx_done),
    .o_timeout       (o_timeout)
  );

  int n_cmp = 0;
  int n_err = 0;

  int         exp_ack[$];
  int         exp_sent[$];
  logic [7:0] exp_byte[$];
  logic [7:0] data[NREQ];

  bit              model_en = 1'b1;
  bit              model_nodone = 1'b0;
  int              m_st = 0;
  int              m_cnt = 0;
  logic [NREQ-1:0] reraise_mask = '0;
  int              reraise_budget = 0;
  int              ack_seen = 0;
  int              sent_seen = 0;
  int              tmo_seen = 0;

  task automatic set_data();
    for (int k = 0; k < NREQ; k++) i_data[8*k +: 8] = data[k];
  endtask

  task automatic push_frame(input int id, input bit expect_sent);
    exp_ack.push_back(id);
    exp_byte.push_back(data[id]);
    if (expect_sent) exp_sent.push_back(id);
  endtask

  task automatic model_reset();
    m_st      = 0;
    m_cnt     = 0;
    tx_active = 1'b0;
    tx_done   = 1'b0;
  endtask

  // One clock: sample DUT at the falling edge, score it, then drive requesters and the uart model.
  task automatic cycle();
    logic [NREQ-1:0] ev;
    int id;
    @(negedge clk);
    if (o_ack != 0 || o_sent != 0) begin
      n_cmp++;
      if ($countones(o_ack) > 1 || $countones(o_sent) > 1 || (o_ack != 0 && o_sent != 0)) begin
        n_err++;
        $display("FAIL pulse_onehot ack=%b sent=%b", o_ack, o_sent);
      end
    end
    if (o_timeout) tmo_seen++;
    if (o_ack != 0) begin
      ack_seen++;
      n_cmp++;
      if (exp_ack.size() == 0) begin
        n_err++;
        $display("FAIL ack_unexpected got=%b", o_ack);
      end else begin
        id = exp_ack.pop_front();
        ev = '0;
        ev[id] = 1'b1;
        if (o_ack !== ev || o_grant_id !== IDW'(id) || o_tx_data_avail !== 1'b1) begin
          n_err++;
          $display("FAIL ack_grant got ack=%b id=%0d avail=%b want ack=%b id=%0d avail=1",
                   o_ack, o_grant_id, o_tx_data_avail, ev, id);
        end
      end
      for (int k = 0; k < NREQ; k++) begin
        if (o_ack[k]) begin
          if (reraise_mask[k] && reraise_budget > 0) reraise_budget--;
          else i_req[k] = 1'b0;
        end
      end
    end
    if (o_sent != 0) begin
      sent_seen++;
      n_cmp++;
      if (exp_sent.size() == 0) begin
        n_err++;
        $display("FAIL sent_unexpected got=%b", o_sent);
      end else begin
        id = exp_sent.pop_front();
        ev = '0;
        ev[id] = 1'b1;
        if (o_sent !== ev) begin
          n_err++;
          $display("FAIL sent_id got=%b want=%b", o_sent, ev);
        end
      end
    end
    if (model_en) begin
      case (m_st)
        0: begin
          tx_done = 1'b0;
          if (o_tx_data_avail) begin
            m_cnt++;
            if (m_cnt >= 2) begin
              tx_active = 1'b1;
              n_cmp++;
              if (exp_byte.size() == 0) begin
                n_err++;
                $display("FAIL byte_unexpected got=%h", o_tx_databyte);
              end else if (o_tx_databyte !== exp_byte[0]) begin
                n_err++;
                $display("FAIL rx_byte got=%h want=%h", o_tx_databyte, exp_byte[0]);
                void'(exp_byte.pop_front());
              end else begin
                void'(exp_byte.pop_front());
              end
              m_st  = 1;
              m_cnt = 0;
            end
          end
        end
        1: begin
          m_cnt++;
          if (m_cnt >= FRAME) begin
            if (!model_nodone) tx_done = 1'b1;
            m_st = 2;
          end
        end
        default: begin
          tx_done   = 1'b0;
          tx_active = 1'b0;
          m_st      = 0;
          m_cnt     = 0;
        end
      endcase
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!(o_busy == 1'b0 && m_st == 0 && exp_sent.size() == 0 && exp_ack.size() == 0) && n < budget);
    if (n >= budget) begin
      n_err++;
      n_cmp++;
      $display("FAIL %s_wait_timeout busy=%b acks_left=%0d sents_left=%0d", name, o_busy, exp_ack.size(), exp_sent.size());
    end
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    i_req = '0;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cycle();
    cycle();
    n_cmp++;
    if ({o_ack, o_sent, o_busy, o_grant_id, o_tx_data_avail, o_tx_databyte, o_timeout} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs ack=%b sent=%b busy=%b id=%0d avail=%b byte=%h tmo=%b want all 0",
               o_ack, o_sent, o_busy, o_grant_id, o_tx_data_avail, o_tx_databyte, o_timeout);
    end
    rst = 1'b0;
    cycle();
    n_cmp++;
    if (o_busy !== 1'b0 || o_tx_data_avail !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_release busy=%b avail=%b want 0/0", o_busy, o_tx_data_avail);
    end
  endtask

  task automatic test_single();
    int s0 = sent_seen;
    data[0] = 8'hAB;
    set_data();
    push_frame(0, 1'b1);
    i_req = 4'b0001;
    cycle();
    n_cmp++;
    if (o_ack !== 4'b0001) begin
      n_err++;
      $display("FAIL single_ack_latency got=%b want=0001", o_ack);
    end
    wait_idle("single", 600);
    n_cmp++;
    if (sent_seen - s0 !== 1 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_sent_count got=%0d busy=%b want 1 busy=0", sent_seen - s0, o_busy);
    end
  endtask

  task automatic test_all_round_robin();
    int s0;
    apply_reset();
    s0 = sent_seen;
    for (int k = 0; k < NREQ; k++) data[k] = 8'h10 + 8'(k);
    set_data();
    for (int f = 0; f < 8; f++) push_frame(f % NREQ, 1'b1);
    reraise_mask   = 4'b1111;
    reraise_budget = 4;
    i_req          = 4'b1111;
    wait_idle("all_rr", 3000);
    reraise_mask = '0;
    n_cmp++;
    if (sent_seen - s0 !== 8 || i_req !== 4'b0000) begin
      n_err++;
      $display("FAIL all_rr_frames got=%0d req=%b want 8 req=0000", sent_seen - s0, i_req);
    end
  endtask

  task automatic test_priority_rotation();
    int n = 0;
    for (int k = 0; k < NREQ; k++) data[k] = 8'hC0 + 8'(k);
    set_data();
    push_frame(2, 1'b1);
    push_frame(1, 1'b1);
    push_frame(2, 1'b1);
    reraise_mask   = 4'b0100;
    reraise_budget = 1;
    i_req          = 4'b0100;
    while (m_st != 1 && n < 50) begin
      cycle();
      n++;
    end
    i_req[1] = 1'b1;
    wait_idle("prio", 2000);
    reraise_mask = '0;
  endtask

  task automatic test_done_inject();
    int s0 = sent_seen;
    model_en = 1'b0;
    tx_done  = 1'b1;
    cycle();
    tx_done = 1'b0;
    cycle();
    n_cmp++;
    if (sent_seen !== s0 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_in_idle sent=%0d busy=%b want 0 busy=0", sent_seen - s0, o_busy);
    end
    data[0] = 8'h3C;
    set_data();
    push_frame(0, 1'b1);
    i_req = 4'b0001;
    cycle();
    tx_done = 1'b1;
    cycle();
    tx_done = 1'b0;
    cycle();
    n_cmp++;
    if (sent_seen !== s0 || o_tx_data_avail !== 1'b1 || o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL done_in_start sent=%0d avail=%b busy=%b want 0/1/1", sent_seen - s0, o_tx_data_avail, o_busy);
    end
    model_reset();
    model_en = 1'b1;
    wait_idle("inject", 600);
    n_cmp++;
    if (sent_seen - s0 !== 1) begin
      n_err++;
      $display("FAIL inject_frame_sent got=%0d want=1", sent_seen - s0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    data[0] = 8'hAB;
    data[3] = 8'h5A;
    set_data();
    push_frame(0, 1'b1);
    i_req = 4'b0001;
    while (!(m_st == 1 && m_cnt > 5) && n < 50) begin
      cycle();
      n++;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({o_ack, o_sent, o_busy, o_grant_id, o_tx_data_avail, o_tx_databyte, o_timeout} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_frame ack=%b sent=%b busy=%b id=%0d avail=%b byte=%h want all 0",
               o_ack, o_sent, o_busy, o_grant_id, o_tx_data_avail, o_tx_databyte);
    end
    exp_sent.delete();
    i_req = '0;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    push_frame(3, 1'b1);
    i_req = 4'b1000;
    wait_idle("post_reset", 600);
  endtask

  task automatic test_timeout();
`ifdef UART_ARB_TIMEOUT_EN
    int n = 0;
    int s0 = sent_seen;
    int t0 = tmo_seen;
    data[0] = 8'h77;
    data[1] = 8'h88;
    set_data();
    push_frame(0, 1'b0);
    push_frame(1, 1'b1);
    model_nodone = 1'b1;
    i_req = 4'b0011;
    cycle();
    while (!o_timeout && n < 200) begin
      cycle();
      n++;
    end
    model_nodone = 1'b0;
    n_cmp++;
    if (n !== TMO || sent_seen !== s0) begin
      n_err++;
      $display("FAIL timeout_latency got=%0d sent=%0d want %0d sent=0", n, sent_seen - s0, TMO);
    end
    wait_idle("timeout", 1500);
    n_cmp++;
    if (tmo_seen - t0 !== 1 || sent_seen - s0 !== 1) begin
      n_err++;
      $display("FAIL timeout_recover tmo=%0d sent=%0d want 1/1", tmo_seen - t0, sent_seen - s0);
    end
`else
    n_cmp++;
    if (tmo_seen !== 0) begin
      n_err++;
      $display("FAIL timeout_tied_low got=%0d pulses want=0", tmo_seen);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_round_robin();
    test_priority_rotation();
    test_done_inject();
    test_reset_mid_frame();
    test_timeout();
    n_cmp++;
    if (exp_ack.size() !== 0 || exp_byte.size() !== 0 || exp_sent.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain ack=%0d byte=%0d sent=%0d want 0/0/0",
               exp_ack.size(), exp_byte.size(), exp_sent.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
